axis_elastic_buffer: RTL
========================

Name: axis_elastic_buffer

Overview:
- Parametrised successor to the single-entry skid buffer: a DEPTH-entry elastic buffer for AXI-stream-style valid/ready links.
- Carries data, keep and last sideband through a circular store.
- Sits between pipeline stages, e.g. ahead of the header-insert datapath, to absorb multi-cycle backpressure.
- o_ready never combinationally depends on i_ready.

Parameters:
- DW, 8, data width in bits (>=1)
- KW, DW/8 (min 1), keep width in bits
- DEPTH, 4, number of storage entries; power of 2, >=2
- CW, $clog2(DEPTH)+1, occupancy counter width (derived; do not override)

Ports:
- i_clk  input  1  clock, all state on rising edge
- i_reset  input  1  asynchronous, active-low reset
- i_valid  input  1  upstream beat valid
- o_ready  output  1  buffer can accept a beat
- i_data  input  DW  upstream data
- i_keep  input  KW  upstream byte enables
- i_last  input  1  upstream end-of-packet
- o_valid  output  1  downstream beat valid
- i_ready  input  1  downstream accepts beat
- o_data  output  DW  downstream data
- o_keep  output  KW  downstream byte enables
- o_last  output  1  downstream end-of-packet
- o_count  output  CW  current occupancy, 0..DEPTH
- o_full  output  1  o_count == DEPTH
- o_empty  output  1  o_count == 0

Behaviour:
- Reset (i_reset low, asynchronous assert): wr_ptr=0, rd_ptr=0, count=0; o_valid=0, o_ready=0, o_count=0, o_empty=1, o_full=0. Storage array is not reset.
- o_data/o_keep/o_last are don't-care while o_valid=0. Deassertion is sampled on the next i_clk edge; the first push can occur on the first edge after release.
- push = i_valid && o_ready; pop = o_valid && i_ready (non-bypass path).
- o_ready = i_reset && !full. It is derived only from registered count, so a full buffer refuses input even if i_ready=1 in that cycle.
- o_valid = i_reset && (count != 0). Output fields are driven from mem[rd_ptr] (head entry).
- Latency: 1 cycle from push to o_valid when empty.
- push only: mem[wr_ptr] <= {i_data,i_keep,i_last}; wr_ptr++; count++.
- pop only: rd_ptr++; count--.
- push and pop in the same cycle: both pointers advance; count unchanged.
  - When count==1, the head is replaced by the new beat next cycle; o_valid stays 1 with no bubble.
- Pointers are log2(DEPTH) bits and wrap naturally from DEPTH-1 to 0. count uses CW bits and never exceeds DEPTH or underflows.
- Full: o_ready=0, i_valid ignored, stored data unchanged.
- Empty: o_valid=0, i_ready ignored, pointers unchanged.
- Beat order is strict FIFO. keep and last travel with their data beat unchanged; the block does not interpret packet boundaries.
- Reset asserted mid-stream: all buffered beats are discarded immediately, and o_valid/o_ready drop in the same cycle.
- Throughput: 1 beat/cycle sustained when downstream is always ready, for any DEPTH>=2.

Optional Feature:
- Macro: AXIS_ELASTIC_BYPASS_EN.
- Defined: zero-latency cut-through when empty.
  - o_valid = i_reset && (count!=0 || i_valid).
  - When count==0, outputs are taken from i_data/i_keep/i_last.
  - When count==0 && i_valid && i_ready, the beat passes straight through: no write, pointers and count unchanged.
  - When count==0 && i_valid && !i_ready, the beat is written as a normal push.
  - When count!=0, behaviour is identical to the non-bypass build.
- Not defined: no combinational path from any i_* input to any o_* output except reset gating; latency is always >=1 cycle.

Test Plan:
- Reset/idle (DW=8, DEPTH=4): hold i_reset=0 for 3 cycles with i_valid=1 -> o_valid=0, o_ready=0, o_count=0, o_empty=1. Release -> o_ready=1 on the next cycle.
- Fill and drain: i_ready=0, push 0x11,0x22,0x33,0x44 -> o_count steps 1..4, o_full=1, o_ready=0; a 5th beat 0x55 is held off. Then i_ready=1 -> outputs 0x11,0x22,0x33,0x44 on consecutive cycles, o_empty=1 after.
- Streaming wrap: i_valid=i_ready=1 continuously for 10 beats 0x00..0x09 -> output matches in order with 1-cycle latency (0 with bypass), o_count constant at 1 (0 with bypass), no bubbles across pointer wrap.
- Sideband integrity: push {data=0xA5, keep=1, last=1} then {0x5A, keep=0, last=0} with random i_ready -> o_keep/o_last arrive with the matching data exactly.
- Simultaneous push/pop at full: fill to 4, then i_valid=1 and i_ready=1 -> pop occurs, push refused that cycle, o_count=3. Next cycle o_ready=1 and the push is accepted.
- Async reset mid-operation: with 3 beats stored, pull i_reset low between clock edges -> o_valid and o_count go to 0 immediately. After release, first output is the first newly pushed beat, not stale data.

Source files
------------

// File: rtl/axis_elastic_buffer.sv
// DEPTH-entry circular valid/ready buffer carrying data/keep/last; 1-cycle latency, o_ready from registered count only.
// Define AXIS_ELASTIC_BYPASS_EN for zero-latency cut-through while empty.
module axis_elastic_buffer #(
  parameter int DW    = 8,
  parameter int KW    = (DW / 8 < 1) ? 1 : DW / 8,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_valid,
  output logic          o_ready,
  input  logic [DW-1:0] i_data,
  input  logic [KW-1:0] i_keep,
  input  logic          i_last,
  output logic          o_valid,
  input  logic          i_ready,
  output logic [DW-1:0] o_data,
  output logic [KW-1:0] o_keep,
  output logic          o_last,
  output logic [CW-1:0] o_count,
  output logic          o_full,
  output logic          o_empty
);

  localparam int AW = $clog2(DEPTH);

  typedef struct packed {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic          last;
  } beat_t;

  beat_t         mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  beat_t         in_beat;
  beat_t         head;
  beat_t         out_beat;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign in_beat = {i_data, i_keep, i_last};
  assign head    = mem[rd_ptr];

  // Ready depends only on registered occupancy, never on downstream ready.
  assign o_ready = i_reset && !full;
  assign pop     = i_reset && !empty && i_ready;

`ifdef AXIS_ELASTIC_BYPASS_EN
  logic cut;

  // An empty buffer hands an accepted beat straight through without storing it.
  assign cut      = empty && i_valid && i_ready;
  assign push     = i_valid && o_ready && !cut;
  assign o_valid  = i_reset && (!empty || i_valid);
  assign out_beat = empty ? in_beat : head;
`else
  assign push     = i_valid && o_ready;
  assign o_valid  = i_reset && !empty;
  assign out_beat = head;
`endif

  assign o_data  = out_beat.data;
  assign o_keep  = out_beat.keep;
  assign o_last  = out_beat.last;
  assign o_count = count;
  assign o_full  = full;
  assign o_empty = empty;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage holds no reset; occupancy alone decides what is valid.
  always_ff @(posedge i_clk) begin
    if (push) mem[wr_ptr] <= in_beat;
  end

endmodule
